// File: rtl/sr_latch_scheduler.sv
// sr_latch_scheduler: round-robin A/B scheduler that pulses S/R into N external SR latches
// and keeps a shadow copy of the latch state, checked against the latch readback.
module sr_latch_scheduler #(
  parameter int N         = 4,
  parameter int IDX_W     = 2,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [IDX_W-1:0] a_idx,
  input  logic             a_op,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [IDX_W-1:0] b_idx,
  input  logic             b_op,
  output logic [N-1:0]     s_out,
  output logic [N-1:0]     r_out,
  input  logic [N-1:0]     q_in,
  output logic [N-1:0]     shadow,
  output logic             busy,
  output logic             done,
  output logic             done_src,
  output logic             cmd_err,
  output logic             chk_err
);
  localparam logic [7:0] P_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] G_LD = 8'(GAP_CYC - 1);
  typedef enum logic [2:0] {INIT, IDLE, DRIVE, GAP, CHECK} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic op_q, op_d, src_q, src_d, bad_q, bad_d, init_q, init_d, last_b_q, last_b_d;
  logic [N-1:0] s_q, s_d, r_q, r_d, shadow_q, shadow_d;
  logic busy_q, done_q, done_d, cmd_err_q, cmd_err_d, chk_err_q, chk_err_d;
  logic grant, g_op, g_bad;
  logic [IDX_W-1:0] g_idx;
  logic [N-1:0] g_oh, g_sh, oh, q_sh;
  assign a_ready = state_q == IDLE && a_valid && (!b_valid || last_b_q);
  assign b_ready = state_q == IDLE && b_valid && !a_ready;
  assign grant   = a_ready | b_ready;
  assign g_idx   = a_ready ? a_idx : b_idx;
  assign g_op    = a_ready ? a_op : b_op;
  assign g_bad   = {1'b0, g_idx} >= (IDX_W+1)'(N);
  // Shifts instead of bit-selects so out-of-range indices read as 0 rather than X.
  assign g_oh    = N'(1) << g_idx;
  assign g_sh    = shadow_q >> g_idx;
  assign oh      = N'(1) << idx_q;
  assign q_sh    = q_in >> idx_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    op_d      = op_q;
    src_d     = src_q;
    bad_d     = bad_q;
    init_d    = init_q;
    last_b_d  = last_b_q;
    s_d       = '0;
    r_d       = '0;
    shadow_d  = shadow_q;
    done_d    = 1'b0;
    cmd_err_d = 1'b0;
    chk_err_d = chk_err_q;
    case (state_q)
      INIT: begin
        state_d = cnt_q == 8'd0 ? GAP : INIT;
        cnt_d   = cnt_q == 8'd0 ? G_LD : cnt_q - 8'd1;
        r_d     = cnt_q == 8'd0 ? '0 : '1;
      end
      IDLE: if (grant) begin
        idx_d    = g_idx;
        op_d     = g_op;
        src_d    = b_ready;
        bad_d    = g_bad;
        last_b_d = b_ready;
        if (g_bad || g_sh[0] == g_op) begin
          state_d   = CHECK;
          done_d    = 1'b1;
          cmd_err_d = g_bad;
        end else begin
          state_d = DRIVE;
          cnt_d   = P_LD;
          s_d     = g_op ? g_oh : '0;
          r_d     = g_op ? '0 : g_oh;
        end
      end
      DRIVE: begin
        state_d = cnt_q == 8'd0 ? GAP : DRIVE;
        cnt_d   = cnt_q == 8'd0 ? G_LD : cnt_q - 8'd1;
        s_d     = cnt_q == 8'd0 ? '0 : s_q;
        r_d     = cnt_q == 8'd0 ? '0 : r_q;
      end
      GAP: begin
        state_d = cnt_q == 8'd0 ? CHECK : GAP;
        cnt_d   = cnt_q == 8'd0 ? cnt_q : cnt_q - 8'd1;
        done_d  = cnt_q == 8'd0 && !init_q;
      end
      CHECK: begin
        state_d = IDLE;
        init_d  = 1'b0;
        if (init_q) chk_err_d = chk_err_q | (|q_in);
        else if (!bad_q) begin
          shadow_d  = op_q ? shadow_q | oh : shadow_q & ~oh;
          chk_err_d = chk_err_q | (q_sh[0] != op_q);
        end
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      cnt_q     <= P_LD;
      idx_q     <= '0;
      op_q      <= 1'b0;
      src_q     <= 1'b0;
      bad_q     <= 1'b0;
      init_q    <= 1'b1;
      last_b_q  <= 1'b1;
      s_q       <= '0;
      r_q       <= '1;
      shadow_q  <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      src_q     <= src_d;
      bad_q     <= bad_d;
      init_q    <= init_d;
      last_b_q  <= last_b_d;
      s_q       <= s_d;
      r_q       <= r_d;
      shadow_q  <= shadow_d;
      busy_q    <= state_d != IDLE;
      done_q    <= done_d;
      cmd_err_q <= cmd_err_d;
      chk_err_q <= chk_err_d;
    end
  end
  assign s_out    = s_q;
  assign r_out    = r_q;
  assign shadow   = shadow_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign done_src = src_q;
  assign cmd_err  = cmd_err_q;
  assign chk_err  = chk_err_q;
endmodule
